csa_serial_add_sequencer: RTL and testbench
===========================================

Name: csa_serial_add_sequencer

Overview:
- Multi-cycle wide adder/subtractor controller. Sequences one shared 4-bit carry-select adder slice (full_adder-based, ports A, B, Cin, Sum, Cout) across NIBBLES nibbles, least-significant first.
- Carry-out of each nibble is registered and fed back as the next nibble's Cin.
- Valid/ready handshake on the operand and result sides. Sits between operand producers and result consumers in the arithmetic datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; W = 4*NIBBLES (default 16); legal range 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  sequencer can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- cout  output  1  carry-out of MSB nibble; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, nibble counter=0, carry reg=0. in_ready=1, because in_ready is decoded from the state.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch a into A shift reg;
    - latch b (or ~b if sub) into B shift reg;
    - carry reg <= sub ? 1 : cin;
    - latch MSBs a[W-1] and b_eff[W-1];
    - counter <= 0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - adder slice gets A[3:0], B[3:0], carry reg;
    - slice Sum is shifted into the top nibble of the result reg (result reg shifts right 4);
    - A and B shift right 4;
    - carry reg <= slice Cout;
    - counter++.
    - When counter==NIBBLES-1, that cycle's update completes and state goes to DONE.
  - DONE: out_valid=1, with sum=result reg, cout=carry reg, ovf=(a_msb==b_eff_msb)&&(sum[W-1]!=a_msb). Outputs are held stable while out_ready=0. On out_ready, go to IDLE and out_valid deasserts next cycle.
- Latency: accept at edge t gives out_valid=1 from edge t+NIBBLES. Throughput: one operation per NIBBLES+2 cycles minimum (accept, NIBBLES RUN cycles, handshake).
- No overlap: in_ready=0 in RUN and DONE. An in_valid asserted there is ignored, and the operands must be held by the producer.
- Operands are sampled only at acceptance. Changes to a, b, cin or sub during RUN/DONE have no effect.
- Width: slice arithmetic is 4-bit modulo 16; the carry between slices is carried only by the carry reg. Final cout is the carry out of bit W-1.
- Subtraction: cout=1 iff a>=b unsigned; ovf uses the inverted b MSB.
- Counter is ceil(log2(NIBBLES)) bits; it wraps only via reset to 0 on acceptance.
- Reset mid-operation (RUN or DONE) aborts immediately:
  - no out_valid pulse;
  - sum/cout/ovf return to 0;
  - the result is lost and must be re-requested.
- out_ready asserted outside DONE has no effect.

Test Plan:
- NIBBLES=4, add a=0x1234, b=0x0FFF, cin=0 -> after 4 cycles out_valid=1, sum=0x2233, cout=0, ovf=0.
- Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; carry reg is 1 after every RUN cycle (full carry ripple across nibbles).
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Add a=0x7FFF, b=0x0001, cin=1 -> sum=0x8001, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> sum/cout/ovf stable, in_ready=0, nothing accepted. out_ready=1 -> IDLE next cycle; new operands accepted on the following edge.
- Assert rst asynchronously mid-clock after 2 RUN cycles -> outputs 0 and in_ready=1 immediately, no out_valid ever. The next operation a=0x0001, b=0x0001 gives sum=0x0002.

Source files
------------

// File: rtl/csa_serial_add_sequencer.sv
// Serial wide adder/subtractor: one shared 4-bit carry-select slice walks the
// operands nibble by nibble (LSB first), with a registered carry between nibbles.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// 4-bit carry-select slice: low pair ripples from Cin, high pair is precomputed
// for both carry values and selected by the low pair's carry-out.
module csa_add4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout
);
   logic [2:0] c_lo;
   logic [1:0] s_lo;
   logic [2:0] c_hi0, c_hi1;
   logic [1:0] s_hi0, s_hi1;

   assign c_lo[0]  = Cin;
   assign c_hi0[0] = 1'b0;
   assign c_hi1[0] = 1'b1;

   for (genvar i = 0; i < 2; i++) begin : g_bits
      full_adder u_lo (
         .a(A[i]), .b(B[i]), .cin(c_lo[i]), .s(s_lo[i]), .cout(c_lo[i+1])
      );
      full_adder u_hi0 (
         .a(A[i+2]), .b(B[i+2]), .cin(c_hi0[i]), .s(s_hi0[i]), .cout(c_hi0[i+1])
      );
      full_adder u_hi1 (
         .a(A[i+2]), .b(B[i+2]), .cin(c_hi1[i]), .s(s_hi1[i]), .cout(c_hi1[i+1])
      );
   end

   assign Sum  = {(c_lo[2] ? s_hi1 : s_hi0), s_lo};
   assign Cout = c_lo[2] ? c_hi1[2] : c_hi0[2];
endmodule

module csa_serial_add_sequencer #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf
);
   localparam int unsigned   W    = 4 * NIBBLES;
   localparam int unsigned   CW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_sh_q, a_sh_d;
   logic [W-1:0]  b_sh_q, b_sh_d;
   logic [W-1:0]  res_q, res_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic          a_msb_q, a_msb_d;
   logic          b_msb_q, b_msb_d;

   logic [W-1:0]  b_eff;
   logic [3:0]    slice_sum;
   logic          slice_cout;
   logic          done;

   csa_add4 u_slice (
      .A   (a_sh_q[3:0]),
      .B   (b_sh_q[3:0]),
      .Cin (carry_q),
      .Sum (slice_sum),
      .Cout(slice_cout)
   );

   assign b_eff = sub ? ~b : b;

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b_eff;
               carry_d = sub ? 1'b1 : cin;
               a_msb_d = a[W-1];
               b_msb_d = b_eff[W-1];
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Each slice result enters at the top so after NIBBLES shifts the
            // first (least significant) nibble has reached bit 0.
            res_d   = {slice_sum, res_q[W-1:4]};
            a_sh_d  = {4'b0000, a_sh_q[W-1:4]};
            b_sh_d  = {4'b0000, b_sh_q[W-1:4]};
            carry_d = slice_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
      end
   end

   assign done      = (state_q == DONE);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = done;
   assign sum       = done ? res_q : '0;
   assign cout      = done & carry_q;
   assign ovf       = done & (a_msb_q == b_msb_q) & (res_q[W-1] != a_msb_q);
endmodule

// File: tb/tb_csa_serial_add_sequencer.sv
// Directed and randomized checks of the serial adder/subtractor against an
// integer-arithmetic reference model.

module tb_csa_serial_add_sequencer;
   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int unsigned checks = 0;
   int unsigned failures = 0;

   csa_serial_add_sequencer #(.NIBBLES(NIB)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the full-width operands.
   task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb,
                        output logic [W-1:0] es, output logic eco, output logic eov);
      longint ua, ub, u, sa, sbv, sres;
      ua  = longint'(av);
      ub  = longint'(bv);
      sa  = longint'($signed(av));
      sbv = longint'($signed(bv));
      if (sb) begin
         u    = ua - ub;
         eco  = (ua >= ub);
         sres = sa - sbv;
      end else begin
         u    = ua + ub + longint'(ci);
         eco  = u[W];
         sres = sa + sbv + longint'(ci);
      end
      es  = u[W-1:0];
      eov = (sres > 32767) || (sres < -32768);
   endtask

   // Entered and left at a negedge with the DUT idle.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input int unsigned hold);
      logic [W-1:0] es;
      logic         eco, eov;
      int unsigned  lat;
      model(av, bv, ci, sb, es, eco, eov);
      a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      chk("in_ready_run", in_ready, 0);
      while (!out_valid && lat < 64) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, NIB);
      for (int unsigned h = 0; h <= hold; h++) begin
         chk("out_valid", out_valid, 1);
         chk("in_ready_done", in_ready, 0);
         chk("sum", sum, es);
         chk("cout", cout, eco);
         chk("ovf", ovf, eov);
         if (h == hold) begin
            out_ready = 1'b1;
         end else begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("out_valid_after_hs", out_valid, 0);
      chk("in_ready_after_hs", in_ready, 1);
   endtask

   initial begin
      int unsigned lat;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
      do_op(16'h7FFF, 16'h0001, 1'b1, 1'b0, 0);
      do_op(16'h1234, 16'h1234, 1'b0, 1'b1, 1);
      do_op(16'h0000, 16'h8000, 1'b0, 1'b1, 0);
      do_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 3);

      for (int i = 0; i < 30; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 2));
      end

      // Asynchronous reset after two RUN cycles.
      a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_cout", cout, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_valid_after_rst", out_valid, 0);
      end
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

      // Asynchronous reset while a result is waiting in DONE.
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk("done_before_rst", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("done_rst_out_valid", out_valid, 0);
      chk("done_rst_sum", sum, 0);
      chk("done_rst_cout", cout, 0);
      chk("done_rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_op(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
